// File: rtl/product_accumulator_if.sv
// Handshake bundle between the upstream multiplier, the product accumulator
// and the downstream consumer of the frame sum.
interface product_accumulator_if #(
  parameter int SUM_W = 10
);
  logic             in_valid;
  logic [5:0]       in_data;
  logic             in_ready;
  logic             clear;
  logic [SUM_W-1:0] sum;
  logic             out_valid;
  logic             out_ready;
  logic             ovf;

  modport master (
    output in_valid, in_data, clear, out_ready,
    input  in_ready, sum, out_valid, ovf
  );

  modport slave (
    input  in_valid, in_data, clear, out_ready,
    output in_ready, sum, out_valid, ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// Sums N_PROD 6-bit products per frame with saturation, then holds the
// result until the downstream side takes it.
module product_accumulator #(
  parameter int N_PROD = 8,
  parameter int SUM_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  product_accumulator_if.slave  bus
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [3:0]     N_LAST  = 4'(N_PROD);
  localparam logic [SUM_W:0] SUM_MAX = {1'b0, {SUM_W{1'b1}}};

  state_t           state_q, state_d;
  logic [3:0]       count_q, count_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;

  logic             accept;
  logic             transfer;
  logic [3:0]       count_inc;
  logic [SUM_W:0]   sum_ext;

  always_comb begin
    accept    = bus.in_valid && (state_q != HOLD);
    transfer  = bus.out_ready && (state_q == HOLD);
    count_inc = count_q + 4'd1;
    sum_ext   = {1'b0, sum_q} + (SUM_W+1)'(bus.in_data);

    state_d = state_q;
    count_d = count_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;

    // clear wins over any accept or transfer in the same cycle
    if (bus.clear || transfer) begin
      state_d = IDLE;
      count_d = '0;
      sum_d   = '0;
      ovf_d   = 1'b0;
    end else if (accept) begin
      count_d = count_inc;
      state_d = (count_inc == N_LAST) ? HOLD : ACCUM;
      if (sum_ext > SUM_MAX) begin
        sum_d = '1;
        ovf_d = 1'b1;
      end else begin
        sum_d = sum_ext[SUM_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q != HOLD);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.sum       = sum_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Drives three accumulator configurations from shared random/directed inputs
// and checks each against a frame-level arithmetic model.
module tb_product_accumulator;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [5:0] in_data = '0;
  logic       clear = 1'b0;
  logic       out_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // instance 0: N=4/W=10, instance 1: N=8/W=8, instance 2: N=1/W=6
  product_accumulator_if #(.SUM_W(10)) ifa ();
  product_accumulator_if #(.SUM_W(8))  ifb ();
  product_accumulator_if #(.SUM_W(6))  ifc ();

  assign ifa.in_valid = in_valid;  assign ifa.in_data = in_data;
  assign ifa.clear = clear;        assign ifa.out_ready = out_ready;
  assign ifb.in_valid = in_valid;  assign ifb.in_data = in_data;
  assign ifb.clear = clear;        assign ifb.out_ready = out_ready;
  assign ifc.in_valid = in_valid;  assign ifc.in_data = in_data;
  assign ifc.clear = clear;        assign ifc.out_ready = out_ready;

  product_accumulator #(.N_PROD(4), .SUM_W(10)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  product_accumulator #(.N_PROD(8), .SUM_W(8))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  product_accumulator #(.N_PROD(1), .SUM_W(6))  dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));

  logic [15:0] d_sum [3];
  logic        d_ovf [3];
  logic        d_ov  [3];
  logic        d_ir  [3];

  assign d_sum[0] = 16'(ifa.sum); assign d_ovf[0] = ifa.ovf;
  assign d_ov[0]  = ifa.out_valid; assign d_ir[0] = ifa.in_ready;
  assign d_sum[1] = 16'(ifb.sum); assign d_ovf[1] = ifb.ovf;
  assign d_ov[1]  = ifb.out_valid; assign d_ir[1] = ifb.in_ready;
  assign d_sum[2] = 16'(ifc.sum); assign d_ovf[2] = ifc.ovf;
  assign d_ov[2]  = ifc.out_valid; assign d_ir[2] = ifc.in_ready;

  // Frame model: products accepted so far and their exact (unsaturated) total
  int nprod [3] = '{4, 8, 1};
  int smax  [3] = '{1023, 255, 63};
  int m_cnt [3];
  int m_tot [3];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst || clear) begin
        m_cnt[i] = 0;
        m_tot[i] = 0;
      end else if (m_cnt[i] == nprod[i]) begin
        if (out_ready) begin
          m_cnt[i] = 0;
          m_tot[i] = 0;
        end
      end else if (in_valid) begin
        m_tot[i] = m_tot[i] + int'(in_data);
        m_cnt[i] = m_cnt[i] + 1;
      end
    end
  end

  task automatic chk(input string name, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0d expected %0d", name, inst, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk("model_sum", i, int'(d_sum[i]), (m_tot[i] > smax[i]) ? smax[i] : m_tot[i]);
      chk("model_ovf", i, int'(d_ovf[i]), (m_tot[i] > smax[i]) ? 1 : 0);
      chk("model_out_valid", i, int'(d_ov[i]), (m_cnt[i] == nprod[i]) ? 1 : 0);
      chk("model_in_ready", i, int'(d_ir[i]), (m_cnt[i] < nprod[i]) ? 1 : 0);
    end
  end

  // Called at a falling edge: apply inputs, then return at the next falling edge
  task automatic cyc(input logic v, input int d, input logic ordy, input logic clr);
    in_valid  = v;
    in_data   = 6'(d);
    out_ready = ordy;
    clear     = clr;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; clear = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_in_ready", 0, int'(ifa.in_ready), 1);
    chk("rst_out_valid", 0, int'(ifa.out_valid), 0);
    chk("rst_sum", 0, int'(ifa.sum), 0);
    chk("rst_ovf", 0, int'(ifa.ovf), 0);

    // 49 x 8: instance 0 completes at 196, instance 1 saturates on the 6th
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 49, 1'b0, 1'b0);
      if (k == 3) chk("a_ov_before_last", 0, int'(ifa.out_valid), 0);
      if (k == 4) begin
        chk("a_ov_4th", 0, int'(ifa.out_valid), 1);
        chk("a_sum_196", 0, int'(ifa.sum), 196);
        chk("a_ovf_196", 0, int'(ifa.ovf), 0);
      end
      if (k == 5) begin
        chk("b_sum_245", 1, int'(ifb.sum), 245);
        chk("b_ovf_5th", 1, int'(ifb.ovf), 0);
      end
      if (k >= 6) begin
        chk("b_sum_sat", 1, int'(ifb.sum), 255);
        chk("b_ovf_sat", 1, int'(ifb.ovf), 1);
      end
    end
    chk("b_ov_8th", 1, int'(ifb.out_valid), 1);
    cyc(1'b0, 0, 1'b0, 1'b0);
    chk("b_ovf_held", 1, int'(ifb.ovf), 1);
    cyc(1'b0, 0, 1'b1, 1'b0);
    chk("b_ovf_after_xfer", 1, int'(ifb.ovf), 0);
    chk("b_sum_after_xfer", 1, int'(ifb.sum), 0);

    // Held frame, stalled consumer, then transfer with in_valid still high
    do_reset();
    for (int k = 1; k <= 4; k++) cyc(1'b1, k, 1'b0, 1'b0);
    chk("a_sum_10", 0, int'(ifa.sum), 10);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 55, 1'b0, 1'b0);
      chk("a_hold_sum", 0, int'(ifa.sum), 10);
      chk("a_hold_in_ready", 0, int'(ifa.in_ready), 0);
    end
    cyc(1'b1, 9, 1'b1, 1'b0);
    chk("a_xfer_sum", 0, int'(ifa.sum), 0);
    chk("a_xfer_ov", 0, int'(ifa.out_valid), 0);
    cyc(1'b1, 9, 1'b0, 1'b0);
    chk("a_first_after_xfer", 0, int'(ifa.sum), 9);

    // clear overrides a simultaneous accept
    do_reset();
    cyc(1'b1, 7, 1'b0, 1'b0);
    cyc(1'b1, 7, 1'b0, 1'b0);
    chk("a_sum_14", 0, int'(ifa.sum), 14);
    cyc(1'b1, 9, 1'b0, 1'b1);
    chk("a_clear_sum", 0, int'(ifa.sum), 0);
    chk("a_clear_in_ready", 0, int'(ifa.in_ready), 1);
    for (int k = 0; k < 4; k++) cyc(1'b1, 1, 1'b0, 1'b0);
    chk("a_sum_4", 0, int'(ifa.sum), 4);
    chk("a_ov_sum_4", 0, int'(ifa.out_valid), 1);

    // Asynchronous reset in HOLD
    do_reset();
    for (int k = 0; k < 4; k++) cyc(1'b1, 5, 1'b0, 1'b0);
    chk("a_sum_20", 0, int'(ifa.sum), 20);
    in_valid = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_out_valid", 0, int'(ifa.out_valid), 0);
    chk("async_sum", 0, int'(ifa.sum), 0);
    chk("async_in_ready", 0, int'(ifa.in_ready), 1);
    @(negedge clk);
    do_reset();

    // N_PROD=1 stream: alternate accept / transfer
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 13, 1'b1, 1'b0);
      chk("c_stream_ov", 2, int'(ifc.out_valid), (k % 2 == 0) ? 1 : 0);
      chk("c_stream_sum", 2, int'(ifc.sum), (k % 2 == 0) ? 13 : 0);
    end

    // Random traffic, including out-of-range products and occasional clear/reset
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) do_reset();
      cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 63)),
          1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0);
    end

    in_valid = 1'b0; clear = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
